fifo_flag_ctrl: RTL and testbench

//  Registered, parametrised FIFO status generator. Next generation of the combinational pointer-compare flag logic.

---
 rtl/fifo_flag_pkg.sv | 25 ++
 rtl/fifo_flag_hyst_cmp.sv | 47 ++++
 rtl/fifo_flag_ctrl.sv | 169 ++++++++++++++++
 tb/tb_fifo_flag_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_flag_pkg.sv
// Shared types and helpers for the FIFO status flag generator.
// Level FSM encoding and saturating threshold arithmetic.
package fifo_flag_pkg;

   typedef enum logic [2:0] {
      S_EMPTY = 3'd0,
      S_LOW   = 3'd1,
      S_MID   = 3'd2,
      S_HIGH  = 3'd3,
      S_FULL  = 3'd4
   } lvl_st_e;

   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int sat_add(input int a, input int b, input int lim);
      return (a + b > lim) ? lim : a + b;
   endfunction

   function automatic int sat_sub(input int a, input int b);
      return (a < b) ? 0 : a - b;
   endfunction

endpackage

// File: rtl/fifo_flag_hyst_cmp.sv
// Threshold comparator with separate set/clear levels and a held flag.
// HI_SIDE=0: set when val<=set, clear when val>clr. HI_SIDE=1: set val>=set, clear val<clr.
module flag_hyst_cmp #(
   parameter int W       = 5,
   parameter bit HI_SIDE = 1'b0,
   parameter bit RST_VAL = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] val_i,
   input  logic [W-1:0] set_lvl_i,
   input  logic [W-1:0] clr_lvl_i,
   output logic         flag_o
);

   logic flag_q, flag_d;
   logic set_hit, clr_hit;

   // set has priority; otherwise clear, otherwise hold
   always_comb begin
      flag_d  = flag_q;
      set_hit = 1'b0;
      clr_hit = 1'b0;
      if (HI_SIDE) begin
         set_hit = val_i >= set_lvl_i;
         clr_hit = val_i < clr_lvl_i;
      end else begin
         set_hit = val_i <= set_lvl_i;
         clr_hit = val_i > clr_lvl_i;
      end
      if (set_hit)
         flag_d = 1'b1;
      else if (clr_hit)
         flag_d = 1'b0;
   end

   // flag register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         flag_q <= RST_VAL;
      else
         flag_q <= flag_d;
   end

   assign flag_o = flag_q;

endmodule

// File: rtl/fifo_flag_ctrl.sv
// Registered FIFO status generator: level, five flags, sticky errors.
// Optional peak-level watermark enabled by defining FLAG_WATERMARK_EN.
module fifo_flag_ctrl
   import fifo_flag_pkg::*;
#(
   parameter int RAM_DEPTH = 8,
   parameter int AE_LVL    = 2,
   parameter int AF_LVL    = 2,
   parameter int HYST      = 1,
   localparam int PW       = $clog2(RAM_DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [PW-1:0] wr_ptr,
   input  logic [PW-1:0] rd_ptr,
   input  logic          wr_req,
   input  logic          rd_req,
   input  logic          cfg_load,
   input  logic [PW-1:0] cfg_ae_lvl,
   input  logic [PW-1:0] cfg_af_lvl,
   input  logic          err_clr,
   input  logic          wm_clr,
   output logic [PW-1:0] level,
   output logic          empty,
   output logic          almost_empty,
   output logic          half_full,
   output logic          almost_full,
   output logic          full,
   output logic          overflow,
   output logic          underflow,
   output logic          ptr_err,
   output logic [PW-1:0] peak_level
);

   localparam int TW = PW + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(RAM_DEPTH);
   localparam logic [PW-1:0] HALF_P  = PW'(RAM_DEPTH / 2);

   lvl_st_e       st_q, st_d;
   logic [PW-1:0] occ, lvl_d, lvl_q;
   logic          bad;
   logic [TW-1:0] occ_s;
   logic [PW-1:0] ae_thr_q, ae_thr_d, af_thr_q, af_thr_d;
   logic [TW-1:0] ae_set, ae_clr, af_set, af_clr;
   logic          ovf_q, ovf_d, udf_q, udf_d, perr_q, perr_d;

   // occupancy, saturated at the depth when the pointers are inconsistent
   always_comb begin
      occ   = wr_ptr - rd_ptr;
      bad   = occ > DEPTH_P;
      lvl_d = bad ? DEPTH_P : occ;
      occ_s = {1'b0, lvl_d};
   end

   // level FSM next state; holds while the pointers are inconsistent
   always_comb begin
      st_d = st_q;
      if (!bad) begin
         unique case (1'b1)
            (occ == '0):                          st_d = S_EMPTY;
            (occ != '0 && occ < HALF_P):          st_d = S_LOW;
            (occ >= HALF_P && occ < DEPTH_P - 1): st_d = S_MID;
            (occ == DEPTH_P - 1):                 st_d = S_HIGH;
            (occ == DEPTH_P):                     st_d = S_FULL;
            default:                              st_d = st_q;
         endcase
      end
   end

   // runtime thresholds, clamped to the depth on load
   always_comb begin
      ae_thr_d = ae_thr_q;
      af_thr_d = af_thr_q;
      if (cfg_load) begin
         ae_thr_d = (cfg_ae_lvl > DEPTH_P) ? DEPTH_P : cfg_ae_lvl;
         af_thr_d = (cfg_af_lvl > DEPTH_P) ? DEPTH_P : cfg_af_lvl;
      end
   end

   // saturating set/clear levels for the hysteresis comparators
   always_comb begin
      ae_set = {1'b0, ae_thr_q};
      ae_clr = TW'(sat_add(int'(ae_thr_q), HYST, RAM_DEPTH));
      af_set = TW'(sat_sub(RAM_DEPTH, int'(af_thr_q)));
      af_clr = TW'(sat_sub(int'(af_set), HYST));
   end

   // sticky error bits; a new event beats err_clr
   always_comb begin
      ovf_d  = (wr_req && full)  || (ovf_q  && !err_clr);
      udf_d  = (rd_req && empty) || (udf_q  && !err_clr);
      perr_d = bad               || (perr_q && !err_clr);
   end

   // state, level, thresholds and error registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q     <= S_EMPTY;
         lvl_q    <= '0;
         ae_thr_q <= PW'(AE_LVL);
         af_thr_q <= PW'(AF_LVL);
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         st_q     <= st_d;
         lvl_q    <= lvl_d;
         ae_thr_q <= ae_thr_d;
         af_thr_q <= af_thr_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         perr_q   <= perr_d;
      end
   end

   flag_hyst_cmp #(.W(TW), .HI_SIDE(1'b0), .RST_VAL(1'b1)) u_ae (
      .clk       (clk),
      .rst       (rst),
      .val_i     (occ_s),
      .set_lvl_i (ae_set),
      .clr_lvl_i (ae_clr),
      .flag_o    (almost_empty)
   );

   flag_hyst_cmp #(.W(TW), .HI_SIDE(1'b1), .RST_VAL(1'b0)) u_af (
      .clk       (clk),
      .rst       (rst),
      .val_i     (occ_s),
      .set_lvl_i (af_set),
      .clr_lvl_i (af_clr),
      .flag_o    (almost_full)
   );

   assign level     = lvl_q;
   assign empty     = (st_q == S_EMPTY);
   assign full      = (st_q == S_FULL);
   assign half_full = (st_q == S_MID) || (st_q == S_HIGH) || (st_q == S_FULL);
   assign overflow  = ovf_q;
   assign underflow = udf_q;
   assign ptr_err   = perr_q;

`ifdef FLAG_WATERMARK_EN
   logic [PW-1:0] peak_q, peak_d;

   // track the highest level; wm_clr restarts from the incoming level
   always_comb begin
      peak_d = peak_q;
      if (wm_clr)
         peak_d = lvl_d;
      else if (lvl_d > peak_q)
         peak_d = lvl_d;
   end

   // peak register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         peak_q <= '0;
      else
         peak_q <= peak_d;
   end

   assign peak_level = peak_q;
`else
   logic unused_wm;
   assign unused_wm  = wm_clr;
   assign peak_level = '0;
`endif

endmodule

// File: tb/tb_fifo_flag_ctrl.sv
// Self-checking bench for fifo_flag_ctrl: directed scenarios plus
// randomized pointers against a behavioural model of the flag rules.
module tb_fifo_flag_ctrl;

   localparam int D  = 8;
   localparam int PW = 4;
   localparam int AE = 2;
   localparam int AF = 2;
   localparam int H  = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          wr_req, rd_req, cfg_load, err_clr, wm_clr;
   logic [PW-1:0] cfg_ae_lvl, cfg_af_lvl;
   logic [PW-1:0] level, peak_level;
   logic          empty, almost_empty, half_full, almost_full, full;
   logic          overflow, underflow, ptr_err;

   int n_chk = 0;
   int n_err = 0;

   // model state = expected outputs
   int m_lvl, m_peak, m_ae_thr, m_af_thr;
   bit m_empty, m_ae, m_half, m_af, m_full, m_ovf, m_udf, m_perr;

   fifo_flag_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .wr_ptr       (wr_ptr),
      .rd_ptr       (rd_ptr),
      .wr_req       (wr_req),
      .rd_req       (rd_req),
      .cfg_load     (cfg_load),
      .cfg_ae_lvl   (cfg_ae_lvl),
      .cfg_af_lvl   (cfg_af_lvl),
      .err_clr      (err_clr),
      .wm_clr       (wm_clr),
      .level        (level),
      .empty        (empty),
      .almost_empty (almost_empty),
      .half_full    (half_full),
      .almost_full  (almost_full),
      .full         (full),
      .overflow     (overflow),
      .underflow    (underflow),
      .ptr_err      (ptr_err),
      .peak_level   (peak_level)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int exp_peak(input int v);
`ifdef FLAG_WATERMARK_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   task automatic model_reset();
      m_lvl = 0; m_peak = 0;
      m_ae_thr = AE; m_af_thr = AF;
      m_empty = 1; m_ae = 1; m_half = 0; m_af = 0; m_full = 0;
      m_ovf = 0; m_udf = 0; m_perr = 0;
   endtask

   task automatic check_all(input string ph);
      check_eq({ph, "_level"}, int'(level), m_lvl);
      check_eq({ph, "_empty"}, int'(empty), int'(m_empty));
      check_eq({ph, "_aempty"}, int'(almost_empty), int'(m_ae));
      check_eq({ph, "_half"}, int'(half_full), int'(m_half));
      check_eq({ph, "_afull"}, int'(almost_full), int'(m_af));
      check_eq({ph, "_full"}, int'(full), int'(m_full));
      check_eq({ph, "_ovf"}, int'(overflow), int'(m_ovf));
      check_eq({ph, "_udf"}, int'(underflow), int'(m_udf));
      check_eq({ph, "_perr"}, int'(ptr_err), int'(m_perr));
      check_eq({ph, "_peak"}, int'(peak_level), exp_peak(m_peak));
   endtask

   task automatic step(input int wp, input int rp,
                       input bit wr = 0, input bit rd = 0,
                       input bit cl = 0, input int ae = 0, input int af = 0,
                       input bit ec = 0, input bit wc = 0);
      int occ, lvl, aclr, base, fclr;
      bit bad, n_ovf, n_udf, n_perr;
      @(negedge clk);
      wr_ptr = PW'(wp); rd_ptr = PW'(rp);
      wr_req = wr; rd_req = rd; cfg_load = cl;
      cfg_ae_lvl = PW'(ae); cfg_af_lvl = PW'(af);
      err_clr = ec; wm_clr = wc;
      #1;
      check_eq("latency_level", int'(level), m_lvl);
      occ = (wp - rp) & ((1 << PW) - 1);
      bad = occ > D;
      lvl = bad ? D : occ;
      n_ovf  = (wr && m_full)  || (m_ovf && !ec);
      n_udf  = (rd && m_empty) || (m_udf && !ec);
      n_perr = bad || (m_perr && !ec);
      if (!bad) begin
         m_empty = (occ == 0);
         m_full  = (occ == D);
         m_half  = (occ >= D / 2);
      end
      aclr = (m_ae_thr + H > D) ? D : m_ae_thr + H;
      if (lvl <= m_ae_thr) m_ae = 1;
      else if (lvl > aclr) m_ae = 0;
      base = (D - m_af_thr < 0) ? 0 : D - m_af_thr;
      fclr = (base - H < 0) ? 0 : base - H;
      if (lvl >= base) m_af = 1;
      else if (lvl < fclr) m_af = 0;
      if (wc) m_peak = lvl;
      else if (lvl > m_peak) m_peak = lvl;
      if (cl) begin
         m_ae_thr = (ae > D) ? D : ae;
         m_af_thr = (af > D) ? D : af;
      end
      m_ovf = n_ovf; m_udf = n_udf; m_perr = n_perr;
      m_lvl = lvl;
      @(posedge clk);
      #1;
      check_all("step");
   endtask

   task automatic idle_inputs();
      wr_ptr = '0; rd_ptr = '0;
      wr_req = 0; rd_req = 0; cfg_load = 0;
      cfg_ae_lvl = '0; cfg_af_lvl = '0;
      err_clr = 0; wm_clr = 0;
   endtask

   task automatic do_mid_reset();
      @(negedge clk);
      rst = 1;
      idle_inputs();
      #1;
      model_reset();
      check_all("midrst");
      @(negedge clk);
      rst = 0;
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      model_reset();
      #12;
      check_eq("rst_level", int'(level), 0);
      check_eq("rst_empty", int'(empty), 1);
      check_eq("rst_aempty", int'(almost_empty), 1);
      check_eq("rst_half", int'(half_full), 0);
      check_eq("rst_afull", int'(almost_full), 0);
      check_eq("rst_full", int'(full), 0);
      check_eq("rst_errs", int'({overflow, underflow, ptr_err}), 0);
      @(negedge clk);
      rst = 0;

      // fill one word per cycle
      for (int i = 1; i <= D; i++) begin
         step(i, 0);
         if (i == 3) check_eq("fill_half3", int'(half_full), 0);
         if (i == 4) check_eq("fill_half4", int'(half_full), 1);
         if (i == 5) check_eq("fill_af5", int'(almost_full), 0);
         if (i == 6) check_eq("fill_af6", int'(almost_full), 1);
         if (i == 7) check_eq("fill_full7", int'(full), 0);
      end
      check_eq("fill_full8", int'(full), 1);
      check_eq("fill_level8", int'(level), D);

      // drain through the hysteresis bands
      for (int r = 1; r <= 6; r++) begin
         step(D, r);
         if (r == 3) check_eq("hyst_af_lvl5", int'(almost_full), 1);
         if (r == 4) check_eq("hyst_af_lvl4", int'(almost_full), 0);
         if (r == 5) check_eq("hyst_ae_lvl3", int'(almost_empty), 0);
      end
      check_eq("hyst_ae_lvl2", int'(almost_empty), 1);
      step(9, 6);
      check_eq("hyst_ae_up3", int'(almost_empty), 1);
      step(10, 6);
      check_eq("hyst_ae_up4", int'(almost_empty), 0);

      // sticky errors
      step(10, 2);
      step(10, 2, 1);
      check_eq("err_ovf_set", int'(overflow), 1);
      step(10, 2);
      check_eq("err_ovf_hold", int'(overflow), 1);
      step(10, 10);
      step(10, 10, 0, 1, 0, 0, 0, 1);
      check_eq("err_udf_win", int'(underflow), 1);
      check_eq("err_ovf_clr", int'(overflow), 0);
      step(12, 0);
      check_eq("err_perr", int'(ptr_err), 1);
      check_eq("err_perr_lvl", int'(level), D);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      check_eq("err_perr_clr", int'(ptr_err), 0);

      // runtime thresholds
      step(0, 0, 0, 0, 1, 5, 12);
      check_eq("cfg_af_load", int'(almost_full), 0);
      step(0, 0);
      check_eq("cfg_af_used", int'(almost_full), 1);
      step(7, 0);
      check_eq("cfg_ae_lvl7", int'(almost_empty), 0);
      step(5, 0);
      check_eq("cfg_ae_lvl5", int'(almost_empty), 1);

      // reset mid-operation restores default thresholds
      do_mid_reset();
      step(3, 0);
      check_eq("rst_thr_af", int'(almost_full), 0);

      // watermark
      step(7, 0);
      step(2, 0);
      check_eq("wm_peak7", int'(peak_level), exp_peak(7));
      step(2, 0, 0, 0, 0, 0, 0, 0, 1);
      check_eq("wm_clr2", int'(peak_level), exp_peak(2));

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         int rp, oc, wp;
         rp = int'($urandom_range(0, 15));
         if ($urandom_range(0, 9) == 0) oc = int'($urandom_range(0, 15));
         else oc = int'($urandom_range(0, D));
         wp = (rp + oc) & 15;
         step(wp, rp,
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              ($urandom_range(0, 15) == 0),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
